seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised Moore sequence detector: serial bit stream x, arbitrary PAT_LEN-bit PATTERN.
//  Successor to the fixed 6-bit detector, with:
//  - qualified input (En)
//  - runtime overlap / non-overlap mode
//  - synchronous clear
//  - optional saturating match counter
//  Sits between the serial receive front-end and the framing/control logic.
// PARAMETERS
//  PAT_LEN  6            pattern length in bits, legal range 2..32
//  PATTERN  6'b101101    pattern; MSB is the first bit received
//  CNT_W    8            match-counter width, legal range 1..16
// PORTS
//  Clock    in   1        single clock; all state on rising edge
//  Reset_n  in   1        asynchronous, active-low reset
//  En       in   1        x is sampled only on edges where En=1
//  x        in   1        serial data bit
//  Overlap  in   1        1: overlapping matches allowed; 0: restart after each match
//  Clear    in   1        synchronous clear of state and counter
//  z        out  1        Moore match flag; 1 iff state == PAT_LEN
//  Count    out  CNT_W    number of matches, saturating
// BEHAVIOUR
//  - State PS ranges 0..PAT_LEN and holds the number of pattern bits currently matched.
//    Width is $clog2(PAT_LEN+1). Async reset: PS=0, z=0, Count=0.
//  - Next state is the KMP automaton over PATTERN.
//    - From PS=k<PAT_LEN: NS = longest prefix of PATTERN that is a suffix of (first k bits, x).
//    - From PS=PAT_LEN with Overlap=1: same rule, where the matched history is the full PATTERN.
//      Example: 101101, x=1 -> 4; x=0 -> 2.
//    - From PS=PAT_LEN with Overlap=0: treat as coming from PS=0, so NS = (x==PATTERN[MSB]) ? 1 : 0.
//  - Priority on each rising edge: Clear > En > hold.
//    - Clear=1: PS<=0, Count<=0.
//    - En=0: PS and Count hold, and z holds its level.
//  - z is decoded from PS only (pure Moore). It rises in the cycle after the edge that accepted
//    the last pattern bit. It falls after the next En edge unless that edge completes another match.
//  - Count increments on every edge where NS==PAT_LEN and is accepted (En=1, Clear=0).
//    It saturates at 2^CNT_W-1 and does not wrap.
//  - Overlap is sampled only on edges leaving PS=PAT_LEN. Changing it mid-sequence has no other effect.
//  - Reset_n asserted mid-pattern: PS=0 immediately and asynchronously. Any partial match is lost.
//  - Illegal PAT_LEN or CNT_W is rejected at elaboration with $error.
// CONFIGURATION
//  - MATCH_COUNT_EN defined: Count register and saturation logic are compiled in as described.
//  - MATCH_COUNT_EN undefined: the counter is removed and Count is tied to 0.
//    z and the FSM are unaffected.
// STRUCTURE
//  - Package seq_det_pkg:
//    - function seq_det_next(pattern, len, k, x), returning the KMP next state for
//      elaboration-time table build
//    - localparam limits PAT_LEN_MAX=32, CNT_W_MAX=16
//  - Sub-module seq_det_next_state: combinational, parameterised by PATTERN/PAT_LEN.
//    Maps (PS, x, Overlap) -> NS using the elaborated table.
//  - Top level contains the PS register, z decode and optional counter.
// TESTING
//  1. Defaults, Overlap=1, En=1, x=101101101:
//     z=1 for one cycle after bit 6 and after bit 9; Count=2.
//  2. Same stream with Overlap=0:
//     z=1 only after bit 6; Count=1.
//  3. x=1011011, Overlap=1:
//     PS after bit 7 is 4; then 01 -> z=1, Count=2.
//  4. En=0 for 3 cycles mid-pattern, with x toggling during the gap:
//     PS unchanged; completing the pattern afterwards gives z=1.
//  5. Clear pulsed while PS=5 and Count=3: PS=0, Count=0, z=0 next cycle.
//     Reset_n pulsed mid-pattern: outputs go to 0 asynchronously.
//  6. CNT_W=2, 5 consecutive matches: Count sticks at 3.
//     Also PAT_LEN=3, PATTERN=3'b111, x=11111 with Overlap=1 -> 3 matches.
//     Rebuild without MATCH_COUNT_EN: Count==0 throughout, z unchanged.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared limits and the KMP next-state function used to elaborate the detector's transition table.
package seq_det_pkg;

    localparam int unsigned PAT_LEN_MAX = 32;
    localparam int unsigned CNT_W_MAX   = 16;

    function automatic logic pat_bit(logic [PAT_LEN_MAX-1:0] pattern, int unsigned idx);
        logic [PAT_LEN_MAX-1:0] sh;
        sh = pattern >> idx;
        return sh[0];
    endfunction

    // History is the first k pattern bits followed by x; return the longest pattern prefix
    // that is also a suffix of that history (k == len covers the overlapping restart).
    function automatic int unsigned seq_det_next(logic [PAT_LEN_MAX-1:0] pattern,
                                                 int unsigned len, int unsigned k, logic x);
        int unsigned best;
        int unsigned j;
        logic        ok;
        logic        hb;
        best = 0;
        for (int unsigned m = 1; m <= PAT_LEN_MAX; m++) begin
            if (m <= len && m <= k + 1) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < PAT_LEN_MAX; i++) begin
                    if (i < m) begin
                        j  = k + 1 - m + i;
                        hb = (j == k) ? x : pat_bit(pattern, len - 1 - j);
                        if (hb != pat_bit(pattern, len - 1 - i)) ok = 1'b0;
                    end
                end
                if (ok) best = m;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational KMP next-state lookup for seq_detector_param, table built at elaboration.
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b101101
) (
    input  logic [$clog2(PAT_LEN+1)-1:0] ps,
    input  logic                         x,
    input  logic                         overlap,
    output logic [$clog2(PAT_LEN+1)-1:0] ns
);

    localparam int unsigned            SW      = $clog2(PAT_LEN + 1);
    localparam int unsigned            NumSt   = 2 ** SW;
    localparam logic [SW-1:0]          PsFull  = SW'(PAT_LEN);
    localparam logic [PAT_LEN_MAX-1:0] PatExt  = PAT_LEN_MAX'(PATTERN);

    // Table is padded to a power of two so any encoding of ps indexes a defined entry.
    logic [SW-1:0] tbl [NumSt][2];

    for (genvar k = 0; k < NumSt; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k <= PAT_LEN) begin : g_legal
                assign tbl[k][b] = SW'(seq_det_next(PatExt, PAT_LEN, k, 1'(b)));
            end else begin : g_pad
                assign tbl[k][b] = '0;
            end
        end
    end

    always_comb begin
        ns = tbl[ps][x];
        if (ps == PsFull && !overlap) begin
            ns = tbl[0][x];
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with qualified input, overlap mode and sync clear.
// Define MATCH_COUNT_EN to compile in the saturating match counter; otherwise Count is 0.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b101101,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             x,
    input  logic             Overlap,
    input  logic             Clear,
    output logic             z,
    output logic [CNT_W-1:0] Count
);

    localparam int unsigned   SW     = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] PsFull = SW'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN out of range 2..32");
    end
    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W out of range 1..16");
    end

    logic [SW-1:0] ps_q;
    logic [SW-1:0] ns;

    seq_det_next_state #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_next_state (
        .ps      (ps_q),
        .x       (x),
        .overlap (Overlap),
        .ns      (ns)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ps_q <= '0;
        end else if (Clear) begin
            ps_q <= '0;
        end else if (En) begin
            ps_q <= ns;
        end
    end

    assign z = (ps_q == PsFull);

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (Clear) begin
            cnt_q <= '0;
        end else if (En && ns == PsFull && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign Count = cnt_q;
`else
    assign Count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: constant vector table plus a behavioural model.
module tb_seq_detector_param;

    logic       Clock;
    logic       Reset_n;
    logic       En;
    logic       x;
    logic       Overlap;
    logic       Clear;
    logic       z_main;
    logic       z_c2;
    logic       z_111;
    logic [7:0] cnt_main;
    logic [1:0] cnt_c2;
    logic [7:0] cnt_111;

    seq_detector_param dut_main (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (En),
        .x       (x),
        .Overlap (Overlap),
        .Clear   (Clear),
        .z       (z_main),
        .Count   (cnt_main)
    );

    seq_detector_param #(
        .CNT_W (2)
    ) dut_c2 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (En),
        .x       (x),
        .Overlap (Overlap),
        .Clear   (Clear),
        .z       (z_c2),
        .Count   (cnt_c2)
    );

    seq_detector_param #(
        .PAT_LEN (3),
        .PATTERN (3'b111)
    ) dut_111 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (En),
        .x       (x),
        .Overlap (Overlap),
        .Clear   (Clear),
        .z       (z_111),
        .Count   (cnt_111)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic clr;
        logic en;
        logic x;
        logic ovl;
        logic ez;
        int   ec;
    } vec_t;

    typedef struct {
        int   id;
        logic z;
        int   cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   nchecks = 0;
    int   nerr    = 0;
    int   step    = 0;

    // Model for dut_c2 (id 0) and dut_111 (id 1): match iff the last len accepted bits since the
    // last restart equal the pattern.
    logic [31:0] m_hist [2];
    int          m_v    [2];
    int          m_cnt  [2];
    logic        m_z    [2];
    int          m_len  [2] = '{6, 3};
    int          m_max  [2] = '{3, 255};
    logic [31:0] m_pat  [2] = '{32'b101101, 32'b111};

    function automatic int cexp(input int c);
`ifdef MATCH_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hist[i] = '0;
            m_v[i]    = 0;
            m_cnt[i]  = 0;
            m_z[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input vec_t v);
        logic [31:0] mask;
        mask = (32'd1 << m_len[i]) - 32'd1;
        if (v.clr) begin
            m_hist[i] = '0;
            m_v[i]    = 0;
            m_cnt[i]  = 0;
            m_z[i]    = 1'b0;
        end else if (v.en) begin
            if (m_z[i] && !v.ovl) m_v[i] = 0;
            m_hist[i] = {m_hist[i][30:0], v.x};
            if (m_v[i] < m_len[i]) m_v[i]++;
            m_z[i] = (m_v[i] == m_len[i]) && ((m_hist[i] & mask) == m_pat[i]);
            if (m_z[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic add(input logic clr, input logic en, input logic xb, input logic ovl,
                       input logic ez, input int ec);
        vec_t v;
        v = '{clr, en, xb, ovl, ez, ec};
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge Clock);
        Clear   = v.clr;
        En      = v.en;
        x       = v.x;
        Overlap = v.ovl;
        e = '{2, v.ez, v.ec};
        sb.push_back(e);
        for (int i = 0; i < 2; i++) begin
            model_step(i, v);
            e = '{i, m_z[i], m_cnt[i]};
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.id)
                0: begin
                    check($sformatf("c2_z[%0d]", step), int'(z_c2), int'(e.z));
                    check($sformatf("c2_cnt[%0d]", step), int'(cnt_c2), cexp(e.cnt));
                end
                1: begin
                    check($sformatf("p111_z[%0d]", step), int'(z_111), int'(e.z));
                    check($sformatf("p111_cnt[%0d]", step), int'(cnt_111), cexp(e.cnt));
                end
                default: begin
                    check($sformatf("main_z[%0d]", step), int'(z_main), int'(e.z));
                    check($sformatf("main_cnt[%0d]", step), int'(cnt_main), cexp(e.cnt));
                end
            endcase
        end
        step++;
    endtask

    task automatic run(input logic clr, input logic en, input logic xb, input logic ovl,
                       input logic ez, input int ec);
        vec_t v;
        v = '{clr, en, xb, ovl, ez, ec};
        apply(v);
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next clock edge.
    task automatic async_reset(input string tag);
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check({tag, "_z"}, int'(z_main), 0);
        check({tag, "_cnt"}, int'(cnt_main), 0);
        check({tag, "_c2_cnt"}, int'(cnt_c2), 0);
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        En      = 1'b0;
        x       = 1'b0;
        Overlap = 1'b1;
        Clear   = 1'b0;
        model_reset();
        @(posedge Clock);
        #1;
        check("reset_main_z", int'(z_main), 0);
        check("reset_main_cnt", int'(cnt_main), 0);
        check("reset_c2_z", int'(z_c2), 0);
        check("reset_c2_cnt", int'(cnt_c2), 0);
        check("reset_111_z", int'(z_111), 0);
        check("reset_111_cnt", int'(cnt_111), 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // 101101101 overlapping: matches after bits 6 and 9
        add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 1, 1);
        add(0, 1, 1, 1, 0, 1); add(0, 1, 0, 1, 0, 1); add(0, 1, 1, 1, 1, 2);
        add(1, 1, 1, 1, 0, 0);
        // same stream non-overlapping: only one match
        add(0, 1, 1, 0, 0, 0); add(0, 1, 0, 0, 0, 0); add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0); add(0, 1, 0, 0, 0, 0); add(0, 1, 1, 0, 1, 1);
        add(0, 1, 1, 0, 0, 1); add(0, 1, 0, 0, 0, 1); add(0, 1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);
        // 1011011 leaves state 4, then 01 completes; run on to state 5 with count 3
        add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 1, 1);
        add(0, 1, 1, 1, 0, 1); add(0, 1, 0, 1, 0, 1); add(0, 1, 1, 1, 1, 2);
        add(0, 1, 1, 1, 0, 2); add(0, 1, 0, 1, 0, 2); add(0, 1, 1, 1, 1, 3);
        add(0, 1, 1, 1, 0, 3); add(0, 1, 0, 1, 0, 3);
        // Clear beats En=0; a following 1 must not complete the pattern
        add(1, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        // En gap with x toggling, then complete; z holds through a second gap
        add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 0, 0); add(0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 1, 1, 1); add(0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 0, 1);

        foreach (tbl[i]) apply(tbl[i]);

        // five back-to-back overlapping matches: CNT_W=2 instance saturates at 3
        run(1, 1, 1, 1, 0, 0);
        run(0, 1, 1, 1, 0, 0); run(0, 1, 0, 1, 0, 0); run(0, 1, 1, 1, 0, 0);
        run(0, 1, 1, 1, 0, 0); run(0, 1, 0, 1, 0, 0); run(0, 1, 1, 1, 1, 1);
        for (int r = 0; r < 4; r++) begin
            run(0, 1, 1, 1, 0, 1 + r);
            run(0, 1, 0, 1, 0, 1 + r);
            run(0, 1, 1, 1, 1, 2 + r);
        end
        check("sat_c2_cnt", int'(cnt_c2), cexp(3));
        check("sat_main_cnt", int'(cnt_main), cexp(5));

        // 11111 overlapping against the 3'b111 instance: three matches
        run(1, 1, 1, 1, 0, 0);
        for (int r = 0; r < 5; r++) run(0, 1, 1, 1, 0, 0);
        check("p111_final_cnt", int'(cnt_111), cexp(3));
        check("p111_final_z", int'(z_111), 1);

        // async reset with a partial match (state 5) and nonzero count
        run(1, 1, 1, 1, 0, 0);
        run(0, 1, 1, 1, 0, 0); run(0, 1, 0, 1, 0, 0); run(0, 1, 1, 1, 0, 0);
        run(0, 1, 1, 1, 0, 0); run(0, 1, 0, 1, 0, 0); run(0, 1, 1, 1, 1, 1);
        run(0, 1, 1, 1, 0, 1); run(0, 1, 0, 1, 0, 1);
        async_reset("arst_ps5");
        run(0, 1, 1, 1, 0, 0);
        // async reset while z is high
        run(0, 1, 0, 1, 0, 0); run(0, 1, 1, 1, 0, 0); run(0, 1, 1, 1, 0, 0);
        run(0, 1, 0, 1, 0, 0); run(0, 1, 1, 1, 1, 1);
        async_reset("arst_ps6");
        run(0, 1, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
